// File: rtl/axi_noc_pkg.sv
// Shared AXI definitions for the 2x2 NoC slave ports: response codes,
// channel FSM state encodings and a small response-encoding helper.
package axi_noc_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word array with one write port and one registered read port (read-first).
// rd_clr forces the read register to zero instead of accessing the array.
module axi_mem_array #(
    parameter int DEPTH  = 4096,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register samples the pre-write value on a same-edge collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_clr) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write and read FSMs.
// AXI_MEM_ADDR_CHECK_EN: flag beats beyond MEM_DEPTH instead of wrapping the index.
module axi_mem_slave
    import axi_noc_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MEM_DEPTH      = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   awid,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                awlen,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_DATA_WIDTH-1:0] wdata,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [AXI_ID_WIDTH-1:0]   bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ID_WIDTH-1:0]   arid,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [AXI_ID_WIDTH-1:0]   rid,
    output logic [AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    output logic                      rlast,
    input  logic                      rready
);

    localparam int LSB    = $clog2(AXI_DATA_WIDTH / 8);
    localparam int WORD_W = 28 - LSB;
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [WORD_W-1:0] WORD_ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    w_state_t w_state_r, w_state_s;
    r_state_t r_state_r, r_state_s;

    logic                    awready_r, wready_r, bvalid_r;
    logic [AXI_ID_WIDTH-1:0] bid_r;
    logic [1:0]              bresp_r;
    logic [WORD_W-1:0]       w_word_r;
    logic [7:0]              w_len_r;
    logic [8:0]              w_cnt_r;
    logic                    w_err_r;

    logic                    arready_r, rvalid_r, rlast_r;
    logic [AXI_ID_WIDTH-1:0] rid_r;
    logic [1:0]              rresp_r;
    logic [WORD_W-1:0]       r_word_r;
    logic [7:0]              r_len_r;
    logic [8:0]              r_cnt_r;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic w_in_range_s, r_in_range_s;
    logic w_over_s, w_bad_s, w_short_s;
    logic mem_wr_en_s, mem_rd_en_s, mem_rd_clr_s;
    logic unused_s;

    assign aw_hs_s = awvalid & awready_r;
    assign w_hs_s  = wvalid & wready_r;
    assign b_hs_s  = bvalid_r & bready;
    assign ar_hs_s = arvalid & arready_r;
    assign r_hs_s  = rvalid_r & rready;

`ifdef AXI_MEM_ADDR_CHECK_EN
    localparam logic [WORD_W:0] DEPTH_LIM = (WORD_W+1)'(MEM_DEPTH);
    assign w_in_range_s = ({1'b0, w_word_r} < DEPTH_LIM);
    assign r_in_range_s = ({1'b0, r_word_r} < DEPTH_LIM);
`else
    logic unused_idx_s;
    assign w_in_range_s = 1'b1;
    assign r_in_range_s = 1'b1;
    assign unused_idx_s = ^{w_word_r[WORD_W-1:IDX_W], r_word_r[WORD_W-1:IDX_W]};
`endif

    // Region decode bits and sub-word offsets are not used by this slave.
    assign unused_s = ^{awaddr[AXI_ADDR_WIDTH-1:28], awaddr[LSB-1:0],
                        araddr[AXI_ADDR_WIDTH-1:28], araddr[LSB-1:0]};

    assign w_over_s    = (w_cnt_r > {1'b0, w_len_r});
    assign w_bad_s     = w_over_s | ~w_in_range_s;
    assign w_short_s   = (w_cnt_r != {1'b0, w_len_r});
    assign mem_wr_en_s = w_hs_s & ~w_bad_s;

    assign mem_rd_en_s  = (r_state_r == R_FETCH) & r_in_range_s;
    assign mem_rd_clr_s = (r_state_r == R_FETCH) & ~r_in_range_s;

    // Write channel next-state.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_state_s = W_DATA; else w_state_s = W_IDLE;
            W_DATA:  if (w_hs_s && wlast) w_state_s = W_RESP; else w_state_s = W_DATA;
            W_RESP:  if (b_hs_s) w_state_s = W_IDLE; else w_state_s = W_RESP;
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write channel state, handshake outputs, beat tracking and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= {AXI_ID_WIDTH{1'b0}};
            bresp_r   <= AXI_RESP_OKAY;
            w_word_r  <= {WORD_W{1'b0}};
            w_len_r   <= 8'd0;
            w_cnt_r   <= 9'd0;
            w_err_r   <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= (w_state_s == W_IDLE);
            wready_r  <= (w_state_s == W_DATA);
            bvalid_r  <= (w_state_s == W_RESP);
            if (aw_hs_s) begin
                bid_r    <= awid;
                w_word_r <= awaddr[27:LSB];
                w_len_r  <= awlen;
                w_cnt_r  <= 9'd0;
                w_err_r  <= 1'b0;
            end else if (w_hs_s) begin
                w_word_r <= w_word_r + WORD_ONE;
                // Saturate so a runaway burst can never wrap back into range.
                w_cnt_r  <= (w_cnt_r == 9'h1FF) ? w_cnt_r : w_cnt_r + 9'd1;
                w_err_r  <= w_err_r | w_bad_s;
                if (wlast) begin
                    bresp_r <= resp_of(w_err_r | w_bad_s | w_short_s);
                end
            end
        end
    end

    // Read channel next-state.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_state_s = R_FETCH; else r_state_s = R_IDLE;
            R_FETCH: r_state_s = R_DATA;
            R_DATA: begin
                if (r_hs_s) begin
                    r_state_s = rlast_r ? R_IDLE : R_FETCH;
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read channel state, handshake outputs and beat attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= {AXI_ID_WIDTH{1'b0}};
            rresp_r   <= AXI_RESP_OKAY;
            r_word_r  <= {WORD_W{1'b0}};
            r_len_r   <= 8'd0;
            r_cnt_r   <= 9'd0;
        end else begin
            r_state_r <= r_state_s;
            arready_r <= (r_state_s == R_IDLE);
            rvalid_r  <= (r_state_s == R_DATA);
            if (ar_hs_s) begin
                rid_r    <= arid;
                r_word_r <= araddr[27:LSB];
                r_len_r  <= arlen;
                r_cnt_r  <= 9'd0;
            end else if (r_state_r == R_FETCH) begin
                rresp_r <= resp_of(~r_in_range_s);
                rlast_r <= (r_cnt_r == {1'b0, r_len_r});
            end else if (r_hs_s && !rlast_r) begin
                r_word_r <= r_word_r + WORD_ONE;
                r_cnt_r  <= r_cnt_r + 9'd1;
            end else begin
                r_cnt_r <= r_cnt_r;
            end
        end
    end

    axi_mem_array #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (AXI_DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_wr_en_s),
        .wr_addr (w_word_r[IDX_W-1:0]),
        .wr_data (wdata),
        .rd_en   (mem_rd_en_s),
        .rd_clr  (mem_rd_clr_s),
        .rd_addr (r_word_r[IDX_W-1:0]),
        .rd_data (rdata)
    );

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bid     = bid_r;
    assign bresp   = bresp_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rlast   = rlast_r;
    assign rid     = rid_r;
    assign rresp   = rresp_r;

endmodule
